// File: rtl/fp_mul_result_stage.sv
// Registered output stage for the single-precision multiplier: 2-entry skid FIFO with
// invalid-result canonicalisation, sticky exception flags and a delivered-result counter.
module fp_mul_result_stage #(
   parameter int unsigned TAG_W     = 4,
   parameter logic [31:0] CANON_NAN = 32'h7FC0_0000,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_result,
   input  logic [3:0]       in_flags,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic [3:0]       out_flags,
   output logic [TAG_W-1:0] out_tag,
   input  logic             flag_clr,
   output logic [3:0]       sticky_flags,
   output logic [CNT_W-1:0] result_cnt
);

   typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

   state_e             state_q, state_d;
   logic               in_ready_q, in_ready_d;
   logic [31:0]        head_res_q, head_res_d, tail_res_q, tail_res_d;
   logic [3:0]         head_flg_q, head_flg_d, tail_flg_q, tail_flg_d;
   logic [TAG_W-1:0]   head_tag_q, head_tag_d, tail_tag_q, tail_tag_d;
   logic [3:0]         sticky_q, sticky_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               acc, pop;
   logic [31:0]        cap_res;

   assign out_valid = (state_q != StEmpty);
   assign acc       = in_valid & in_ready_q;
   assign pop       = out_valid & out_ready;
   assign cap_res   = in_flags[3] ? CANON_NAN : in_result;

   always_comb begin
      state_d    = state_q;
      head_res_d = head_res_q;
      head_flg_d = head_flg_q;
      head_tag_d = head_tag_q;
      tail_res_d = tail_res_q;
      tail_flg_d = tail_flg_q;
      tail_tag_d = tail_tag_q;
      unique case (state_q)
         StEmpty: begin
            if (acc) begin
               head_res_d = cap_res;
               head_flg_d = in_flags;
               head_tag_d = in_tag;
               state_d    = StOne;
            end
         end
         StOne: begin
            if (acc && pop) begin
               head_res_d = cap_res;
               head_flg_d = in_flags;
               head_tag_d = in_tag;
            end else if (acc) begin
               tail_res_d = cap_res;
               tail_flg_d = in_flags;
               tail_tag_d = in_tag;
               state_d    = StFull;
            end else if (pop) begin
               state_d = StEmpty;
            end
         end
         StFull: begin
            // in_ready is low here, so only a pop can move the FIFO
            if (pop) begin
               head_res_d = tail_res_q;
               head_flg_d = tail_flg_q;
               head_tag_d = tail_tag_q;
               state_d    = StOne;
            end
         end
         default: state_d = StEmpty;
      endcase
      in_ready_d = (state_d != StFull);
      sticky_d   = (flag_clr ? 4'h0 : sticky_q) | (acc ? in_flags : 4'h0);
      cnt_d      = pop ? cnt_q + CNT_W'(1) : cnt_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StEmpty;
         in_ready_q <= 1'b1;
         head_res_q <= '0;
         head_flg_q <= '0;
         head_tag_q <= '0;
         tail_res_q <= '0;
         tail_flg_q <= '0;
         tail_tag_q <= '0;
         sticky_q   <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         head_res_q <= head_res_d;
         head_flg_q <= head_flg_d;
         head_tag_q <= head_tag_d;
         tail_res_q <= tail_res_d;
         tail_flg_q <= tail_flg_d;
         tail_tag_q <= tail_tag_d;
         sticky_q   <= sticky_d;
         cnt_q      <= cnt_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign out_result   = head_res_q;
   assign out_flags    = head_flg_q;
   assign out_tag      = head_tag_q;
   assign sticky_flags = sticky_q;
   assign result_cnt   = cnt_q;

endmodule

// File: tb/tb_fp_mul_result_stage.sv
// Randomised self-checking bench for fp_mul_result_stage against a queue-based reference model.
module tb_fp_mul_result_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, flag_clr;
   logic [31:0] in_result, out_result;
   logic [3:0]  in_flags, out_flags, in_tag, out_tag, sticky_flags;
   logic [15:0] result_cnt;

   int checks = 0;
   int errors = 0;

   logic [31:0] mq_res[$];
   logic [3:0]  mq_flg[$];
   logic [3:0]  mq_tag[$];
   logic [3:0]  m_sticky;
   logic [15:0] m_cnt;

   fp_mul_result_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_result   (in_result),
      .in_flags    (in_flags),
      .in_tag      (in_tag),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_flags   (out_flags),
      .out_tag     (out_tag),
      .flag_clr    (flag_clr),
      .sticky_flags(sticky_flags),
      .result_cnt  (result_cnt)
   );

   always #5 clk = ~clk;

   // Drives one cycle of inputs, advances one clock edge and updates the model.
   task automatic cycle(input logic iv, input logic [31:0] r, input logic [3:0] f,
                        input logic [3:0] t, input logic ordy, input logic clr);
      bit acc, pop;
      in_valid  = iv;
      in_result = r;
      in_flags  = f;
      in_tag    = t;
      out_ready = ordy;
      flag_clr  = clr;
      acc = rst_n && iv && (mq_res.size() < 2);
      pop = rst_n && ordy && (mq_res.size() > 0);
      @(posedge clk);
      if (!rst_n) begin
         mq_res.delete();
         mq_flg.delete();
         mq_tag.delete();
         m_sticky = 4'h0;
         m_cnt    = 16'h0;
      end else begin
         m_sticky = (clr ? 4'h0 : m_sticky) | (acc ? f : 4'h0);
         if (pop) begin
            void'(mq_res.pop_front());
            void'(mq_flg.pop_front());
            void'(mq_tag.pop_front());
            m_cnt = m_cnt + 16'd1;
         end
         if (acc) begin
            mq_res.push_back(f[3] ? 32'h7FC0_0000 : r);
            mq_flg.push_back(f);
            mq_tag.push_back(t);
         end
      end
      #1;
   endtask

   task automatic idle(input logic ordy);
      cycle(1'b0, 32'h0, 4'h0, 4'h0, ordy, 1'b0);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      idle(1'b0);
      idle(1'b0);
      rst_n = 1'b1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_hs: valid=%b ready=%b want 0 1", out_valid, in_ready);
      end
      checks++;
      if (out_result !== 32'h0 || out_flags !== 4'h0 || out_tag !== 4'h0) begin
         errors++;
         $display("FAIL reset_data: %h %h %h want 0", out_result, out_flags, out_tag);
      end
      checks++;
      if (sticky_flags !== 4'h0 || result_cnt !== 16'h0) begin
         errors++;
         $display("FAIL reset_stat: sticky=%h cnt=%h want 0", sticky_flags, result_cnt);
      end
   endtask

   task automatic test_basic;
      cycle(1'b1, 32'h40C0_0000, 4'b0001, 4'd3, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'h40C0_0000 || out_tag !== 4'd3) begin
         errors++;
         $display("FAIL basic_out: v=%b r=%h t=%h want 1 40c00000 3", out_valid, out_result,
                  out_tag);
      end
      checks++;
      if (sticky_flags !== 4'b0001) begin
         errors++;
         $display("FAIL basic_sticky: got %b want 0001", sticky_flags);
      end
      idle(1'b1);
      checks++;
      if (result_cnt !== 16'd1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_cnt: cnt=%0d v=%b want 1 0", result_cnt, out_valid);
      end
   endtask

   task automatic test_order;
      logic [15:0] c0;
      c0 = m_cnt;
      cycle(1'b1, 32'h3F80_0000, 4'h0, 4'd1, 1'b0, 1'b0);
      cycle(1'b1, 32'h4000_0000, 4'h0, 4'd2, 1'b0, 1'b0);
      checks++;
      if (in_ready !== 1'b0 || out_result !== 32'h3F80_0000) begin
         errors++;
         $display("FAIL order_full: ready=%b r=%h want 0 3f800000", in_ready, out_result);
      end
      idle(1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'h4000_0000 || out_tag !== 4'd2) begin
         errors++;
         $display("FAIL order_second: v=%b r=%h t=%h want 1 40000000 2", out_valid, out_result,
                  out_tag);
      end
      idle(1'b1);
      checks++;
      if (result_cnt !== c0 + 16'd2 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL order_cnt: cnt=%0d v=%b want %0d 0", result_cnt, out_valid, c0 + 16'd2);
      end
   endtask

   task automatic test_canon;
      cycle(1'b1, 32'hFFFF_FFFF, 4'b1000, 4'd7, 1'b0, 1'b0);
      checks++;
      if (out_result !== 32'h7FC0_0000 || out_flags !== 4'b1000 || sticky_flags[3] !== 1'b1) begin
         errors++;
         $display("FAIL canon: r=%h f=%b s=%b want 7fc00000 1000 1xxx", out_result, out_flags,
                  sticky_flags);
      end
      idle(1'b1);
   endtask

   task automatic test_sticky_clr;
      cycle(1'b0, 32'h0, 4'h0, 4'h0, 1'b1, 1'b1);
      cycle(1'b1, 32'h1234_5678, 4'b0100, 4'd5, 1'b1, 1'b0);
      checks++;
      if (sticky_flags !== 4'b0100) begin
         errors++;
         $display("FAIL sticky_set: got %b want 0100", sticky_flags);
      end
      cycle(1'b1, 32'h1111_1111, 4'b0011, 4'd6, 1'b1, 1'b1);
      checks++;
      if (sticky_flags !== 4'b0011) begin
         errors++;
         $display("FAIL sticky_clr_acc: got %b want 0011", sticky_flags);
      end
      idle(1'b1);
   endtask

   task automatic test_full_hold;
      logic [31:0] r0;
      logic [3:0]  s0, t0;
      cycle(1'b1, 32'hAAAA_0001, 4'h2, 4'd8, 1'b0, 1'b0);
      cycle(1'b1, 32'hAAAA_0002, 4'h1, 4'd9, 1'b0, 1'b0);
      r0 = out_result;
      t0 = out_tag;
      s0 = sticky_flags;
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, $urandom, 4'($urandom), 4'($urandom), 1'b0, 1'b0);
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== r0 || out_tag !== t0 ||
             sticky_flags !== s0 || r0 !== 32'hAAAA_0001) begin
            errors++;
            $display("FAIL full_hold[%0d]: rdy=%b v=%b r=%h t=%h s=%b want 0 1 aaaa0001 8 %b",
                     i, in_ready, out_valid, out_result, out_tag, sticky_flags, m_sticky);
         end
      end
      idle(1'b1);
      idle(1'b1);
   endtask

   task automatic test_random;
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom), $urandom, 4'($urandom), 4'($urandom), 1'($urandom),
               ($urandom_range(0, 9) == 0));
         checks++;
         if (out_valid !== (mq_res.size() > 0) || in_ready !== (mq_res.size() < 2)) begin
            errors++;
            $display("FAIL rand_hs[%0d]: v=%b rdy=%b want %b %b", i, out_valid, in_ready,
                     mq_res.size() > 0, mq_res.size() < 2);
         end
         if (mq_res.size() > 0) begin
            checks++;
            if (out_result !== mq_res[0] || out_flags !== mq_flg[0] || out_tag !== mq_tag[0]) begin
               errors++;
               $display("FAIL rand_data[%0d]: %h %b %h want %h %b %h", i, out_result, out_flags,
                        out_tag, mq_res[0], mq_flg[0], mq_tag[0]);
            end
         end
         checks++;
         if (sticky_flags !== m_sticky || result_cnt !== m_cnt) begin
            errors++;
            $display("FAIL rand_stat[%0d]: s=%b cnt=%0d want %b %0d", i, sticky_flags,
                     result_cnt, m_sticky, m_cnt);
         end
      end
      idle(1'b1);
      idle(1'b1);
   endtask

   task automatic test_wrap;
      for (int i = 0; i < 70000 && m_cnt != 16'hFFFF; i++)
         cycle(1'b1, $urandom, 4'h0, 4'($urandom), 1'b1, 1'b0);
      checks++;
      if (result_cnt !== m_cnt || m_cnt !== 16'hFFFF) begin
         errors++;
         $display("FAIL wrap_preload: cnt=%h model=%h want ffff", result_cnt, m_cnt);
      end
      idle(1'b1);
      checks++;
      if (result_cnt !== 16'h0000) begin
         errors++;
         $display("FAIL wrap_zero: cnt=%h want 0000", result_cnt);
      end
   endtask

   task automatic test_reset_full;
      cycle(1'b1, 32'h5555_0001, 4'h4, 4'd1, 1'b0, 1'b0);
      cycle(1'b1, 32'h5555_0002, 4'h2, 4'd2, 1'b0, 1'b0);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL prefull: rdy=%b v=%b want 0 1", in_ready, out_valid);
      end
      rst_n = 1'b0;
      cycle(1'b1, 32'h9999_9999, 4'hF, 4'hF, 1'b1, 1'b0);
      rst_n = 1'b1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || sticky_flags !== 4'h0 ||
          result_cnt !== 16'h0) begin
         errors++;
         $display("FAIL reset_full: v=%b rdy=%b s=%b cnt=%0d want 0 1 0000 0", out_valid,
                  in_ready, sticky_flags, result_cnt);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_result = '0;
      in_flags  = '0;
      in_tag    = '0;
      out_ready = 1'b0;
      flag_clr  = 1'b0;
      m_sticky  = '0;
      m_cnt     = '0;
      test_reset();
      test_basic();
      test_order();
      test_canon();
      test_sticky_clr();
      test_full_hold();
      test_random();
      test_wrap();
      test_reset_full();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
